// File: rtl/axi_rd_pkg.sv
// Shared definitions for the AXI4-Lite sequential reader.
//   rd_state_e   : sequencer states
//   RESP_*       : AXI RRESP encodings
//   resp_is_err  : true for any response other than OKAY
package axi_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // EXOKAY is not expected on AXI4-Lite, so anything but OKAY is flagged
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_rd_watchdog.sv
// Handshake watchdog for the sequential reader.
// Counts cycles while en is high; any handshake (clr) or en low restarts it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : sequencer is waiting on the bus (ADDR or DATA)
//   clr        : an AR or R handshake completes this cycle
//   fire_c     : combinational, high in the LIMIT-th consecutive waiting cycle
module axi_rd_watchdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic fire_c
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] cnt;

  // cycles already spent waiting, saturating at LIMIT-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || clr) begin
      cnt <= '0;
    end else if (cnt != CW'(LIMIT - 1)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign fire_c = en && !clr && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/axi_lite_seq_reader.sv
// AXI4-Lite master that issues count_i single reads at base, base+stride, ...
// with at most one read outstanding, and streams every beat out on rd_*.
// Optional feature: define AXI_RD_TIMEOUT_EN to add a handshake watchdog
// (axi_rd_watchdog); otherwise timeout_o is tied low and the reader waits
// forever.
// Ports:
//   ACLK, ARESETN             : clock, asynchronous active-low reset
//   start_i, abort_i          : launch / stop at the next beat boundary
//   base_addr_i, stride_i,
//   count_i                   : sequence setup, latched on accepted start
//   busy_o, done_o            : sequence active / one-cycle completion pulse
//   err_o, timeout_o,
//   aborted_o                 : sticky status, cleared by the next start
//   rd_valid_o, rd_data_o,
//   rd_resp_o, rd_index_o     : per-beat result stream
//   M_AXI_AR*, M_AXI_R*       : AXI4-Lite read channels
module axi_lite_seq_reader
  import axi_rd_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              timeout_o,
  output logic              aborted_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [1:0]        rd_resp_o,
  output logic [CNT_W-1:0]  rd_index_o,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  rd_state_e         state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  index_q;
  logic              abort_pend;
  logic              arvalid_q;
  logic              rready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              aborted_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [1:0]        rd_resp_q;
  logic [CNT_W-1:0]  rd_index_q;

  logic              last_beat_c;
  logic              abort_now_c;
  logic              wd_fire_c;

  assign last_beat_c = (index_q == count_q - CNT_W'(1));
  // an abort arriving in the completing cycle still counts for this beat
  assign abort_now_c = abort_pend || abort_i;

`ifdef AXI_RD_TIMEOUT_EN
  logic timeout_q;
  logic wd_en_c;
  logic wd_clr_c;

  assign wd_en_c  = (state == ST_ADDR) || (state == ST_DATA);
  assign wd_clr_c = ((state == ST_ADDR) && M_AXI_ARREADY) ||
                    ((state == ST_DATA) && M_AXI_RVALID);

  axi_rd_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .en     (wd_en_c),
    .clr    (wd_clr_c),
    .fire_c (wd_fire_c)
  );

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
  assign wd_fire_c          = 1'b0;
  assign timeout_o          = 1'b0;
`endif

  // Sequencer: ARVALID/RREADY are state-aligned registers, so ARADDR (addr_q)
  // cannot move while ARVALID is up.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      count_q    <= '0;
      index_q    <= '0;
      abort_pend <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      aborted_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_resp_q  <= '0;
      rd_index_q <= '0;
`ifdef AXI_RD_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            addr_q     <= base_addr_i;
            stride_q   <= stride_i;
            count_q    <= count_i;
            index_q    <= '0;
            abort_pend <= 1'b0;
            err_q      <= 1'b0;
            aborted_q  <= 1'b0;
`ifdef AXI_RD_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            busy_q     <= 1'b1;
            if (count_i == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state     <= ST_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end

        ST_ADDR: begin
          if (abort_i) begin
            abort_pend <= 1'b1;
          end
          if (wd_fire_c) begin
            arvalid_q <= 1'b0;
`ifdef AXI_RD_TIMEOUT_EN
            timeout_q <= 1'b1;
`endif
            state     <= ST_DONE;
            done_q    <= 1'b1;
          end else if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (wd_fire_c) begin
            rready_q  <= 1'b0;
`ifdef AXI_RD_TIMEOUT_EN
            timeout_q <= 1'b1;
`endif
            state     <= ST_DONE;
            done_q    <= 1'b1;
          end else if (M_AXI_RVALID) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= M_AXI_RDATA;
            rd_resp_q  <= M_AXI_RRESP;
            rd_index_q <= index_q;
            if (resp_is_err(M_AXI_RRESP)) begin
              err_q <= 1'b1;
            end
            addr_q   <= addr_q + stride_q;
            index_q  <= index_q + CNT_W'(1);
            rready_q <= 1'b0;
            if (last_beat_c || abort_now_c) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              if (abort_now_c) begin
                aborted_q <= 1'b1;
              end
            end else begin
              state     <= ST_ADDR;
              arvalid_q <= 1'b1;
            end
          end else if (abort_i) begin
            abort_pend <= 1'b1;
          end
        end

        ST_DONE: begin
          busy_q     <= 1'b0;
          abort_pend <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign aborted_o     = aborted_q;
  assign rd_valid_o    = rd_valid_q;
  assign rd_data_o     = rd_data_q;
  assign rd_resp_o     = rd_resp_q;
  assign rd_index_o    = rd_index_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_seq_reader.sv
// Directed bench for axi_lite_seq_reader with a configurable-latency slave.
// Slave read data is address ^ 32'h5A5A_0000.
module tb_axi_lite_seq_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] base_addr;
  logic [31:0] stride;
  logic [15:0] count;
  logic        busy, done, err, timeout, aborted;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic [15:0] rd_index;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  axi_lite_seq_reader dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .start_i       (start),
    .abort_i       (abort),
    .base_addr_i   (base_addr),
    .stride_i      (stride),
    .count_i       (count),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .timeout_o     (timeout),
    .aborted_o     (aborted),
    .rd_valid_o    (rd_valid),
    .rd_data_o     (rd_data),
    .rd_resp_o     (rd_resp),
    .rd_index_o    (rd_index),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  int          ar_wait = 0;
  int          r_wait = 0;
  int          slv_err_beat = -1;
  logic        ar_block = 1'b0;
  int          ar_cnt, r_cnt, beat_n;
  logic        pend;
  logic [31:0] lat_addr;

  assign arready = arvalid && !ar_block && (ar_cnt >= ar_wait);
  assign rvalid  = pend && (r_cnt >= r_wait);
  assign rdata   = lat_addr ^ 32'h5A5A_0000;
  assign rresp   = (beat_n == slv_err_beat) ? 2'b10 : 2'b00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_cnt <= 0; r_cnt <= 0; beat_n <= 0; pend <= 1'b0; lat_addr <= '0;
    end else begin
      if (start) beat_n <= 0;
      if (arvalid && !arready) ar_cnt <= ar_cnt + 1;
      else ar_cnt <= 0;
      if (arvalid && arready) begin
        pend <= 1'b1; lat_addr <= araddr; r_cnt <= 0;
      end else if (pend && rvalid && rready) begin
        pend <= 1'b0; beat_n <= beat_n + 1;
      end else if (pend && !rvalid) begin
        r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- monitor (samples on negedge) ----------------
  logic [31:0] ar_q[$];
  logic [31:0] bd_q[$];
  logic [15:0] bi_q[$];
  logic [1:0]  br_q[$];
  logic        be_q[$];
  int          bc_q[$];
  int          done_cnt, done_cyc, first_ar, ar_rise, stab_err, to_cyc;
  logic        p_arvalid, p_hs;
  logic [31:0] p_addr;

  always @(negedge clk) begin
    if (rst_n) begin
      if (arvalid && !p_arvalid) begin
        ar_rise++;
        if (first_ar < 0) first_ar = cyc;
      end
      if (arvalid && p_arvalid && !p_hs && araddr != p_addr) stab_err++;
      if (arvalid && arready) ar_q.push_back(araddr);
      if (rd_valid) begin
        bd_q.push_back(rd_data); bi_q.push_back(rd_index);
        br_q.push_back(rd_resp); be_q.push_back(err); bc_q.push_back(cyc);
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (timeout && to_cyc < 0) to_cyc = cyc;
    end
    p_arvalid = arvalid && rst_n;
    p_hs      = arvalid && arready;
    p_addr    = araddr;
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    ar_q.delete(); bd_q.delete(); bi_q.delete(); br_q.delete();
    be_q.delete(); bc_q.delete();
    done_cnt = 0; done_cyc = -1; first_ar = -1; ar_rise = 0;
    stab_err = 0; to_cyc = -1;
  endtask

  int t0;

  // start a sequence; t0 is the cycle right after the accepting edge
  task automatic launch(input logic [31:0] b, input logic [31:0] s, input logic [15:0] c);
    clr_mon();
    base_addr = b; stride = s; count = c; start = 1'b1;
    tick();
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    for (int i = 0; i < lim && done_cnt == 0; i++) tick();
    tick(3);
    chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    base_addr = '0; stride = '0; count = '0;
    clr_mon();
    p_arvalid = 1'b0; p_hs = 1'b0; p_addr = '0;
    tick(3);

    // reset state
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_araddr",  64'(araddr),  64'd0);
    chk("rst_rready",  64'(rready),  64'd0);
    chk("rst_flags",   64'({done, err, timeout, aborted, rd_valid}), 64'd0);
    rst_n = 1'b1;
    tick(3);
    chk("idle_no_ar", 64'(ar_rise), 64'd0);

    // zero-wait, base 0x100 stride 4 count 3
    launch(32'h100, 32'h4, 16'd3);
    wait_done("zw", 50);
    chk("zw_nar",   64'(ar_q.size()), 64'd3);
    chk("zw_ar0",   64'(ar_q[0]), 64'h100);
    chk("zw_ar1",   64'(ar_q[1]), 64'h104);
    chk("zw_ar2",   64'(ar_q[2]), 64'h108);
    chk("zw_nbeat", 64'(bi_q.size()), 64'd3);
    chk("zw_idx0",  64'(bi_q[0]), 64'd0);
    chk("zw_idx2",  64'(bi_q[2]), 64'd2);
    chk("zw_dat0",  64'(bd_q[0]), 64'h5A5A_0100);
    chk("zw_dat2",  64'(bd_q[2]), 64'h5A5A_0108);
    chk("zw_err",   64'(err), 64'd0);
    chk("zw_ar_lat",   64'(first_ar - t0), 64'd0);
    chk("zw_rd0_lat",  64'(bc_q[0] - t0), 64'd2);
    chk("zw_rd2_lat",  64'(bc_q[2] - t0), 64'd6);
    chk("zw_done_lat", 64'(done_cyc - t0), 64'd6);
    chk("zw_busy_end", 64'(busy), 64'd0);

    // slow slave: ARREADY after 5 cycles, RVALID after 3
    ar_wait = 5; r_wait = 3;
    launch(32'h2000, 32'h10, 16'd2);
    wait_done("slow", 100);
    chk("slow_stable", 64'(stab_err), 64'd0);
    chk("slow_ar1",    64'(ar_q[1]), 64'h2010);
    chk("slow_dat0",   64'(bd_q[0]), 64'h5A5A_2000);
    chk("slow_dat1",   64'(bd_q[1]), 64'h5A5A_2010);
    ar_wait = 0; r_wait = 0;

    // SLVERR on beat 1 of 4
    slv_err_beat = 1;
    launch(32'h3000, 32'h4, 16'd4);
    wait_done("slv", 50);
    chk("slv_nbeat", 64'(bi_q.size()), 64'd4);
    chk("slv_resp1", 64'(br_q[1]), 64'd2);
    chk("slv_resp2", 64'(br_q[2]), 64'd0);
    chk("slv_err_b0", 64'(be_q[0]), 64'd0);
    chk("slv_err_b1", 64'(be_q[1]), 64'd1);
    chk("slv_err_end", 64'(err), 64'd1);
    slv_err_beat = -1;

    // address wrap; also sticky err must clear on new start
    launch(32'hFFFF_FFF8, 32'h8, 16'd2);
    wait_done("wrap", 50);
    chk("wrap_ar0",  64'(ar_q[0]), 64'hFFFF_FFF8);
    chk("wrap_ar1",  64'(ar_q[1]), 64'h0);
    chk("wrap_dat1", 64'(bd_q[1]), 64'h5A5A_0000);
    chk("wrap_err_clr", 64'(err), 64'd0);
    chk("wrap_timeout", 64'(timeout), 64'd0);

    // abort during beat 2 of 10
    launch(32'h400, 32'h4, 16'd10);
    for (int i = 0; i < 50 && ar_rise < 3; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("abt", 50);
    tick(10);
    chk("abt_nbeat",   64'(bi_q.size()), 64'd3);
    chk("abt_lastidx", 64'(bi_q[bi_q.size()-1]), 64'd2);
    chk("abt_flag",    64'(aborted), 64'd1);
    chk("abt_no_more_ar", 64'(ar_rise), 64'd3);

    // start and abort together in IDLE: abort ignored, aborted clears
    abort = 1'b1;
    launch(32'h500, 32'h4, 16'd1);
    abort = 1'b0;
    wait_done("sa", 50);
    chk("sa_aborted", 64'(aborted), 64'd0);
    chk("sa_nbeat",   64'(bi_q.size()), 64'd1);

    // count 0: immediate done, no AXI traffic
    launch(32'h600, 32'h4, 16'd0);
    wait_done("c0", 20);
    chk("c0_no_ar", 64'(ar_rise), 64'd0);
    chk("c0_done_lat", 64'(done_cyc - t0), 64'd0);

`ifdef AXI_RD_TIMEOUT_EN
    // ARREADY never asserts: watchdog fires 256 cycles after ARVALID rises
    ar_block = 1'b1;
    launch(32'h700, 32'h4, 16'd2);
    for (int i = 0; i < 400 && to_cyc < 0; i++) tick();
    tick(3);
    chk("to_lat",     64'(to_cyc - first_ar), 64'd256);
    chk("to_flag",    64'(timeout), 64'd1);
    chk("to_arvalid", 64'(arvalid), 64'd0);
    chk("to_done",    64'(done_cnt), 64'd1);
    ar_block = 1'b0;
`endif

    // asynchronous reset mid-sequence
    ar_wait = 20;
    launch(32'h800, 32'h4, 16'd3);
    tick(3);
    chk("mid_pre_arvalid", 64'(arvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_arvalid", 64'(arvalid), 64'd0);
    chk("mid_araddr",  64'(araddr),  64'd0);
    chk("mid_busy",    64'(busy),    64'd0);
    chk("mid_flags",   64'({done, err, timeout, aborted, rd_valid, rready}), 64'd0);
    tick(2);
    ar_wait = 0;
    rst_n = 1'b1;
    clr_mon();
    tick(10);
    chk("mid_post_no_ar", 64'(ar_rise), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_seq_reader.md
AXI_LITE_SEQ_READER -- requirements
Module: axi_lite_seq_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI read address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI read data width (32 or 64).
REQ-003 SHALL have parameter CNT_W, default 16, width of transfer count and index.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 256, watchdog limit in ACLK cycles.
REQ-005 SHALL have one clock; reset is asynchronous and active-low: ACLK in 1 clock; ARESETN in 1 asynchronous active-low reset.
REQ-006 SHALL have ports: start_i in 1 launch a sequence; abort_i in 1 stop at next beat boundary; base_addr_i in ADDR_W first address; stride_i in ADDR_W address increment; count_i in CNT_W number of reads.
REQ-007 SHALL have ports: busy_o out 1 sequence active; done_o out 1 completion pulse; err_o out 1 sticky non-OKAY RRESP seen; timeout_o out 1 sticky watchdog fired; aborted_o out 1 sticky abort taken.
REQ-008 SHALL have ports: rd_valid_o out 1 beat strobe; rd_data_o out DATA_W beat data; rd_resp_o out 2 beat RRESP; rd_index_o out CNT_W beat number from 0.
REQ-009 SHALL have AXI4-Lite master read ports: M_AXI_ARADDR out ADDR_W; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1; M_AXI_RDATA in DATA_W; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Function
REQ-010 SHALL implement FSM IDLE, ADDR, DATA, DONE; one outstanding read at most.
REQ-011 IDLE: start_i high latches base, stride, count; count=0 -> DONE; else -> ADDR; start_i ignored outside IDLE.
REQ-012 ADDR: ARVALID=1, ARADDR held constant until ARVALID&&ARREADY; then -> DATA; ARVALID never withdrawn before handshake except on timeout.
REQ-013 DATA: RREADY=1; on RVALID&&RREADY: register RDATA/RRESP/index, pulse rd_valid_o one cycle next edge; address += stride, modulo 2^ADDR_W wrap; index += 1.
REQ-014 After a beat: last beat or abort pending -> DONE; else -> ADDR.
REQ-015 abort_i sampled any cycle in ADDR/DATA, held pending until current beat completes; sets aborted_o.
REQ-016 RRESP != 2'b00 SHALL set err_o; sequence continues.
REQ-017 DONE: done_o one-cycle pulse, -> IDLE; busy_o high in ADDR, DATA, DONE.
REQ-018 Sticky flags clear on the cycle a new start_i is accepted.
REQ-019 Latency, zero-wait slave: start_i cycle 0, ARVALID cycle 1, beat every 2 cycles, rd_valid_o 1 cycle after R handshake.
REQ-020 start_i and abort_i in same IDLE cycle: start accepted, abort ignored.

Reset
REQ-021 ARESETN low: state IDLE; all outputs, flags, counters, address 0, immediately, mid-sequence included.
REQ-022 Reset release: no AXI activity until start_i.

Configuration
REQ-023 With AXI_RD_TIMEOUT_EN defined: counter resets on every handshake, counts in ADDR/DATA; at TIMEOUT_CYC cycles without handshake sets timeout_o, drops ARVALID/RREADY, -> DONE.
REQ-024 Without AXI_RD_TIMEOUT_EN: no watchdog logic; timeout_o tied 0; waits indefinitely.

Structure
REQ-025 Package axi_rd_pkg SHALL hold state enum, RRESP constants (OKAY, EXOKAY, SLVERR, DECERR).
REQ-026 Watchdog SHALL be sub-module axi_rd_watchdog, instantiated only under AXI_RD_TIMEOUT_EN.

Verification
REQ-027 base 0x100, stride 4, count 3, zero-wait slave -> ARADDR 0x100/0x104/0x108, indices 0..2, done_o once, err_o 0.
REQ-028 ARREADY delayed 5 cycles, RVALID delayed 3 -> ARADDR stable throughout, data matches slave.
REQ-029 beat 1 RRESP=SLVERR -> err_o set after beat 1, all 4 beats delivered.
REQ-030 base 0xFFFFFFF8, stride 8, count 2 -> second ARADDR 0x00000000.
REQ-031 abort_i during beat 2 of 10 -> beat 2 completes, done_o, aborted_o=1, no further ARVALID.
REQ-032 AXI_RD_TIMEOUT_EN, ARREADY tied 0 -> timeout_o at cycle 257 after ARVALID; ARESETN low mid-sequence -> all outputs 0 same cycle.
